mgmt_pll_reconfig_seq: RTL and testbench



---
 rtl/mgmt_pll_reconfig_seq_pkg.sv | 70 +++++++
 rtl/mgmt_pll_reconfig_seq_sync.sv | 22 ++
 rtl/mgmt_pll_reconfig_seq.sv | 160 ++++++++++++++++
 tb/tb_mgmt_pll_reconfig_seq.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_pll_reconfig_seq_pkg.sv
// Shared LTPI types plus the PLL reconfiguration tables and sequencer states.
// Holds link state/speed enums, base speed, reconfig addresses and per-speed data words.
package mgmt_pll_reconfig_seq_pkg;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_COMMA_HUNTING,
        ST_WAIT_LINK_DETECT_LOCKED,
        ST_LINK_DETECT,
        ST_WAIT_LINK_SPEED_LOCKED,
        ST_LINK_SPEED,
        ST_LINK_SPEED_CHANGE,
        ST_ACCEPT,
        ST_OPERATIONAL
    } rstate_t;

    typedef enum logic [2:0] {
        SPEED_X1  = 3'd0,
        SPEED_X2  = 3'd1,
        SPEED_X4  = 3'd2,
        SPEED_X8  = 3'd3,
        SPEED_X16 = 3'd4
    } link_speed_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLL_RST,
        S_WRITE,
        S_START,
        S_WAIT_LOCK,
        S_DONE
    } pll_seq_state_t;

    localparam link_speed_t LTPI_BASE_SPEED = SPEED_X1;
    localparam logic [5:0]  PLL_START_ADDR  = 6'h02;
    localparam int          TIMER_1MS_60MHZ = 60000;

    // Word order: M counter, N counter, C0 counter, bandwidth.
    function automatic logic [5:0] pll_cfg_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    pll_cfg_addr = 6'h04;
            4'd1:    pll_cfg_addr = 6'h03;
            4'd2:    pll_cfg_addr = 6'h05;
            4'd3:    pll_cfg_addr = 6'h08;
            default: pll_cfg_addr = {2'b01, idx};
        endcase
    endfunction

    function automatic logic [31:0] pll_cfg_data(input link_speed_t spd,
                                                 input logic [3:0]  idx);
        logic [31:0] m;
        logic [31:0] c;
        logic [31:0] bw;
        case (spd)
            SPEED_X2:  begin m = 32'h0000_1010; c = 32'h0000_0404; bw = 32'h7; end
            SPEED_X4:  begin m = 32'h0000_2020; c = 32'h0000_0404; bw = 32'h8; end
            SPEED_X8:  begin m = 32'h0000_2020; c = 32'h0000_0202; bw = 32'h8; end
            SPEED_X16: begin m = 32'h0000_2020; c = 32'h0002_0101; bw = 32'h8; end
            default:   begin m = 32'h0000_0808; c = 32'h0000_0404; bw = 32'h6; end
        endcase
        case (idx)
            4'd0:    pll_cfg_data = m;
            4'd1:    pll_cfg_data = 32'h0001_0000;
            4'd2:    pll_cfg_data = c;
            4'd3:    pll_cfg_data = bw;
            default: pll_cfg_data = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/mgmt_pll_reconfig_seq_sync.sv
// Two-flop synchronizer cell for single-bit asynchronous inputs.
// Ports: clk, reset (async high), d (async in), q (synchronized out).
module mgmt_pll_reconfig_seq_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mgmt_pll_reconfig_seq.sv
// LTPI link PLL reconfiguration sequencer: resets the PLL, writes the target
// frequency words, starts it and waits for lock, with bounded retries.
// Ports: pll_reconfig/LTPI_link_ST/operational_speed request side,
// cfg_* reconfig port, pll_areset/pll_locked PLL side, done/status outputs.
module mgmt_pll_reconfig_seq
    import mgmt_pll_reconfig_seq_pkg::*;
#(
    parameter int CFG_WORDS    = 4,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = TIMER_1MS_60MHZ,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pll_reconfig,
    input  rstate_t     LTPI_link_ST,
    input  link_speed_t operational_speed,
    output logic        pll_configuration_done,
    output logic        change_freq_st,
    output logic [5:0]  cfg_address,
    output logic [31:0] cfg_writedata,
    output logic        cfg_write,
    input  logic        cfg_waitrequest,
    output logic        pll_areset,
    input  logic        pll_locked,
    output logic        pll_lock_err,
    output logic        reconfig_busy
);

    pll_seq_state_t state;
    pll_seq_state_t state_nxt;

    logic        locked_s;
    logic        req_q;
    logic        start;
    logic        tmo;
    logic        lock_ok;
    logic        lock_fail;
    logic        tgt_op;
    link_speed_t tgt_spd;
    logic [31:0] cnt;
    logic [3:0]  idx;
    logic [7:0]  retry;

    mgmt_pll_reconfig_seq_sync u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_locked),
        .q     (locked_s)
    );

    assign start     = (state == S_IDLE) && pll_reconfig && !req_q;
    assign lock_ok   = (state == S_WAIT_LOCK) && locked_s;
    assign tmo       = (state == S_WAIT_LOCK) && !locked_s
                     && (cnt == 32'(LOCK_TIMEOUT - 1));
    assign lock_fail = tmo && (retry >= 8'(MAX_RETRY - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:
                if (start) state_nxt = S_PLL_RST;
            S_PLL_RST:
                if (cnt == 32'(RST_CYCLES - 1)) state_nxt = S_WRITE;
            S_WRITE:
                if (!cfg_waitrequest && idx == 4'(CFG_WORDS - 1))
                    state_nxt = S_START;
            S_START:
                if (!cfg_waitrequest) state_nxt = S_WAIT_LOCK;
            S_WAIT_LOCK:
                if (lock_ok || lock_fail) state_nxt = S_DONE;
                else if (tmo)             state_nxt = S_PLL_RST;
            S_DONE:
                if (!pll_reconfig) state_nxt = S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    // Port drive is purely a function of state, so a stalled word stays put.
    always_comb begin
        cfg_write     = 1'b0;
        cfg_address   = 6'h0;
        cfg_writedata = 32'h0;
        pll_areset    = 1'b0;
        reconfig_busy = 1'b0;
        unique case (state)
            S_PLL_RST: begin
                pll_areset    = 1'b1;
                reconfig_busy = 1'b1;
            end
            S_WRITE: begin
                pll_areset    = 1'b1;
                reconfig_busy = 1'b1;
                cfg_write     = 1'b1;
                cfg_address   = pll_cfg_addr(idx);
                cfg_writedata = pll_cfg_data(tgt_spd, idx);
            end
            S_START: begin
                pll_areset    = 1'b1;
                reconfig_busy = 1'b1;
                cfg_write     = 1'b1;
                cfg_address   = PLL_START_ADDR;
                cfg_writedata = 32'd1;
            end
            S_WAIT_LOCK: reconfig_busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q                  <= 1'b0;
            cnt                    <= 32'h0;
            idx                    <= 4'h0;
            retry                  <= 8'h0;
            tgt_op                 <= 1'b0;
            tgt_spd                <= LTPI_BASE_SPEED;
            pll_configuration_done <= 1'b0;
            change_freq_st         <= 1'b0;
            pll_lock_err           <= 1'b0;
        end else begin
            req_q <= pll_reconfig;
            // One counter serves both the reset hold and the lock timer.
            if (state_nxt != state)
                cnt <= 32'h0;
            else if (state == S_PLL_RST || state == S_WAIT_LOCK)
                cnt <= cnt + 32'd1;
            if (state == S_PLL_RST)
                idx <= 4'h0;
            else if (state == S_WRITE && !cfg_waitrequest)
                idx <= idx + 4'd1;
            if (start) begin
                retry   <= 8'h0;
                tgt_op  <= (LTPI_link_ST == ST_LINK_SPEED_CHANGE);
                tgt_spd <= (LTPI_link_ST == ST_LINK_SPEED_CHANGE)
                         ? operational_speed : LTPI_BASE_SPEED;
                if (LTPI_link_ST != ST_LINK_SPEED_CHANGE)
                    change_freq_st <= 1'b0;
            end
            if (tmo && !lock_fail)
                retry <= retry + 8'd1;
            if (lock_ok) begin
                pll_lock_err   <= 1'b0;
                change_freq_st <= tgt_op;
            end
            if (lock_fail) begin
                pll_lock_err   <= 1'b1;
                change_freq_st <= 1'b0;
            end
            pll_configuration_done <= (state_nxt == S_DONE) && pll_reconfig;
        end
    end

endmodule

// File: tb/tb_mgmt_pll_reconfig_seq.sv
// Self-checking bench for mgmt_pll_reconfig_seq: random requests against a
// transaction-level model of written words, hold/lock timing and status flags.
module tb_mgmt_pll_reconfig_seq;
    import mgmt_pll_reconfig_seq_pkg::*;

    localparam int RSTC  = 16;
    localparam int WORDS = 4;
    localparam int TMO   = 40;
    localparam int RETRY = 3;

    logic        clk;
    logic        reset;
    logic        pll_reconfig;
    rstate_t     LTPI_link_ST;
    link_speed_t operational_speed;
    logic        pll_configuration_done;
    logic        change_freq_st;
    logic [5:0]  cfg_address;
    logic [31:0] cfg_writedata;
    logic        cfg_write;
    logic        cfg_waitrequest;
    logic        pll_areset;
    logic        pll_locked;
    logic        pll_lock_err;
    logic        reconfig_busy;

    mgmt_pll_reconfig_seq #(
        .CFG_WORDS    (WORDS),
        .RST_CYCLES   (RSTC),
        .LOCK_TIMEOUT (TMO),
        .MAX_RETRY    (RETRY)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .pll_reconfig           (pll_reconfig),
        .LTPI_link_ST           (LTPI_link_ST),
        .operational_speed      (operational_speed),
        .pll_configuration_done (pll_configuration_done),
        .change_freq_st         (change_freq_st),
        .cfg_address            (cfg_address),
        .cfg_writedata          (cfg_writedata),
        .cfg_write              (cfg_write),
        .cfg_waitrequest        (cfg_waitrequest),
        .pll_areset             (pll_areset),
        .pll_locked             (pll_locked),
        .pll_lock_err           (pll_lock_err),
        .reconfig_busy          (reconfig_busy)
    );

    logic [5:0]  EXP_ADDR [5] = '{6'h04, 6'h03, 6'h05, 6'h08, 6'h02};
    logic [31:0] EXP_DATA [5][4] = '{
        '{32'h0000_0808, 32'h0001_0000, 32'h0000_0404, 32'h6},
        '{32'h0000_1010, 32'h0001_0000, 32'h0000_0404, 32'h7},
        '{32'h0000_2020, 32'h0001_0000, 32'h0000_0404, 32'h8},
        '{32'h0000_2020, 32'h0001_0000, 32'h0000_0202, 32'h8},
        '{32'h0000_2020, 32'h0001_0000, 32'h0002_0101, 32'h8}
    };

    int total;
    int bad;

    logic [37:0] wr_q [$];
    int          hold_q [$];
    int          wl_q [$];
    int          hold_run;
    int          wl_run;
    int          stall_cnt;
    bit          prev_stall;
    logic [37:0] prev_wr;

    int ws_mode;
    int stall_left;
    bit lock_en;
    int lock_delay;
    int lowcnt;
    bit exp_cfs;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reconfig port slave: no stalls, random stalls, or 3 stalls on word 2.
    initial begin
        cfg_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ws_mode == 1) begin
                cfg_waitrequest = cfg_write && ($urandom_range(0, 2) == 0);
            end else if (ws_mode == 2) begin
                if (cfg_write && cfg_address == EXP_ADDR[2] && stall_left > 0) begin
                    cfg_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    cfg_waitrequest = 1'b0;
                end
            end else begin
                cfg_waitrequest = 1'b0;
            end
        end
    end

    // PLL model: loses lock under reset, locks lock_delay cycles after release.
    initial begin
        pll_locked = 1'b0;
        lowcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (pll_areset) begin
                pll_locked = 1'b0;
                lowcnt = 0;
            end else begin
                lowcnt++;
                if (lock_en && lowcnt >= lock_delay) pll_locked = 1'b1;
                if (!lock_en) pll_locked = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            hold_run = 0;
            wl_run = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold",
                      64'({cfg_write, cfg_address, cfg_writedata}),
                      64'({1'b1, prev_wr}));
            prev_stall = cfg_write && cfg_waitrequest;
            prev_wr = {cfg_address, cfg_writedata};
            if (cfg_write && cfg_waitrequest) stall_cnt++;
            if (cfg_write && !cfg_waitrequest)
                wr_q.push_back({cfg_address, cfg_writedata});
            if (pll_areset && !cfg_write) begin
                hold_run++;
            end else if (hold_run != 0) begin
                hold_q.push_back(hold_run);
                hold_run = 0;
            end
            if (reconfig_busy && !pll_areset) begin
                wl_run++;
            end else if (wl_run != 0) begin
                wl_q.push_back(wl_run);
                wl_run = 0;
            end
        end
    end

    task automatic clear_obs();
        wr_q.delete();
        hold_q.delete();
        wl_q.delete();
        stall_cnt = 0;
    endtask

    task automatic run_seq(input rstate_t st, input link_speed_t spd,
                           input int d, input int mode, input bit lk);
        bit          op;
        bit          old;
        bit          prev_cfs;
        int          ts;
        int          cyc;
        int          att;
        int          nwr;
        link_speed_t tgt;
        op  = (st == ST_LINK_SPEED_CHANGE);
        tgt = op ? spd : SPEED_X1;
        ts  = int'(tgt);
        att = lk ? 1 : RETRY;
        old = exp_cfs;
        @(negedge clk);
        clear_obs();
        lock_en = lk;
        lock_delay = d;
        ws_mode = mode;
        stall_left = 3;
        LTPI_link_ST = st;
        operational_speed = spd;
        pll_reconfig = 1'b1;
        prev_cfs = change_freq_st;
        cyc = 0;
        while (!pll_configuration_done && cyc < 800) begin
            @(negedge clk);
            cyc++;
            operational_speed = link_speed_t'($urandom_range(0, 4));
            if (cyc == 1) begin
                check("cfs_at_start", 64'(change_freq_st), 64'(op ? old : 1'b0));
                check("areset_rise", 64'(pll_areset), 64'd1);
            end
            if (!pll_configuration_done) prev_cfs = change_freq_st;
        end
        check("done_seen", 64'(pll_configuration_done), 64'd1);
        if (lk)
            check("latency", 64'(cyc), 64'(RSTC + WORDS + 4 + d + stall_cnt));
        check("cfs_prev", 64'(prev_cfs), 64'(op ? old : 1'b0));
        check("cfs_done", 64'(change_freq_st), 64'(lk && op));
        check("lock_err", 64'(pll_lock_err), 64'(!lk));
        if (mode == 2) check("stalls", 64'(stall_cnt), 64'd3);
        @(negedge clk);
        check("n_words", 64'(wr_q.size()), 64'(att * (WORDS + 1)));
        for (int i = 0; i < wr_q.size(); i++) begin
            int w;
            w = i % (WORDS + 1);
            check("wr_addr", 64'(wr_q[i][37:32]), 64'(EXP_ADDR[w]));
            check("wr_data", 64'(wr_q[i][31:0]),
                  w == WORDS ? 64'd1 : 64'(EXP_DATA[ts][w]));
        end
        check("n_attempts", 64'(hold_q.size()), 64'(att));
        foreach (hold_q[i]) check("rst_hold", 64'(hold_q[i]), 64'(RSTC));
        check("n_waits", 64'(wl_q.size()), 64'(att));
        foreach (wl_q[i]) check("lock_wait", 64'(wl_q[i]), 64'(lk ? d + 2 : TMO));
        nwr = wr_q.size();
        repeat ($urandom_range(2, 6)) @(negedge clk);
        check("held_done", 64'(pll_configuration_done), 64'd1);
        check("held_idle", 64'({reconfig_busy, pll_areset}), 64'd0);
        check("held_nowr", 64'(wr_q.size()), 64'(nwr));
        pll_reconfig = 1'b0;
        @(negedge clk);
        check("done_drop", 64'(pll_configuration_done), 64'd0);
        exp_cfs = lk && op;
        ws_mode = 0;
    endtask

    initial begin
        int cyc;
        bit saw;
        total = 0;
        bad = 0;
        ws_mode = 0;
        stall_left = 0;
        lock_en = 1'b1;
        lock_delay = 1;
        exp_cfs = 1'b0;
        stall_cnt = 0;
        reset = 1'b1;
        pll_reconfig = 1'b0;
        LTPI_link_ST = ST_INIT;
        operational_speed = SPEED_X1;
        repeat (3) @(negedge clk);
        check("rst_ctl", 64'({pll_configuration_done, change_freq_st, cfg_write,
                              pll_areset, pll_lock_err, reconfig_busy}), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ctl", 64'({pll_configuration_done, change_freq_st, cfg_write,
                               pll_areset, pll_lock_err, reconfig_busy}), 64'd0);
        check("idle_port", 64'({cfg_address, cfg_writedata}), 64'd0);

        run_seq(ST_INIT, SPEED_X4, 10, 0, 1'b1);
        run_seq(ST_LINK_SPEED_CHANGE, SPEED_X4, 10, 0, 1'b1);
        run_seq(ST_INIT, SPEED_X2, 3, 0, 1'b1);
        run_seq(ST_LINK_SPEED_CHANGE, SPEED_X16, 2, 2, 1'b1);
        run_seq(ST_INIT, SPEED_X1, 1, 0, 1'b0);
        run_seq(ST_LINK_SPEED_CHANGE, SPEED_X8, 4, 1, 1'b1);

        // Request dropped mid-sequence: finishes quietly, never signals done.
        @(negedge clk);
        clear_obs();
        lock_en = 1'b1;
        lock_delay = 3;
        LTPI_link_ST = ST_INIT;
        pll_reconfig = 1'b1;
        repeat (5) @(negedge clk);
        pll_reconfig = 1'b0;
        cyc = 0;
        saw = 1'b0;
        while (reconfig_busy && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (pll_configuration_done) saw = 1'b1;
        end
        repeat (2) begin
            @(negedge clk);
            if (pll_configuration_done) saw = 1'b1;
        end
        check("abort_done", 64'(saw), 64'd0);
        check("abort_idle", 64'(reconfig_busy), 64'd0);
        check("abort_words", 64'(wr_q.size()), 64'(WORDS + 1));
        check("abort_cfs", 64'(change_freq_st), 64'd0);
        exp_cfs = 1'b0;

        // Get to operational speed, then reset in the middle of WRITE.
        run_seq(ST_LINK_SPEED_CHANGE, SPEED_X2, 2, 0, 1'b1);
        @(negedge clk);
        clear_obs();
        LTPI_link_ST = ST_LINK_SPEED_CHANGE;
        operational_speed = SPEED_X8;
        pll_reconfig = 1'b1;
        cyc = 0;
        while (wr_q.size() < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("pre_rst_write", 64'(cfg_write), 64'd1);
        reset = 1'b1;
        pll_reconfig = 1'b0;
        #1;
        check("mid_rst_ctl", 64'({pll_configuration_done, change_freq_st, cfg_write,
                                  pll_areset, pll_lock_err, reconfig_busy}), 64'd0);
        check("mid_rst_port", 64'({cfg_address, cfg_writedata}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_cfs = 1'b0;
        @(negedge clk);
        run_seq(ST_LINK_SPEED_CHANGE, SPEED_X8, 2, 0, 1'b1);

        for (int n = 0; n < 8; n++) begin
            rstate_t     st;
            link_speed_t sp;
            if ($urandom_range(0, 1) == 1) st = ST_LINK_SPEED_CHANGE;
            else st = rstate_t'($urandom_range(0, 5));
            sp = link_speed_t'($urandom_range(0, 4));
            run_seq(st, sp, int'($urandom_range(1, 8)),
                    int'($urandom_range(0, 1)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
